ringbuf_seq: RTL and testbench

RINGBUF_SEQ -- requirements
Module: ringbuf_seq

---
 rtl/ringbuf_pkg.sv | 10 +
 rtl/ringbuf_seq.sv | 112 +++++++++++
 tb/tb_ringbuf_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ringbuf_pkg.sv
// rtl/ringbuf_pkg.sv - shared types for the ring buffer sequencer
package ringbuf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ringbuf_seq.sv
// rtl/ringbuf_seq.sv - steps a sibling ring buffer through npasses full rotations
module ringbuf_seq
    import ringbuf_pkg::*;
#(
    parameter int nwords = 8,
    parameter int npbits = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic [npbits-1:0]         npasses,
    input  logic                      wr_mode,
    input  logic                      adv,
    input  logic                      abort,
    output logic                      en,
    output logic                      wren,
    output logic [$clog2(nwords)-1:0] idx,
    output logic [npbits-1:0]         pass,
    output logic                      first,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    localparam int IW = $clog2(nwords);
    localparam logic [IW-1:0] LAST_IDX = IW'(nwords - 1);

    if (nwords < 2) begin : g_bad_nwords
        $error("ringbuf_seq: nwords must be at least 2");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [npbits-1:0] pass_q, pass_d;
    logic [npbits-1:0] npasses_q, npasses_d;
    logic              wr_mode_q, wr_mode_d;
    logic              step;
    logic              wrap;

    // en is combinational from adv so the consumer sees the shift in the same cycle
    assign step = (state_q == RUN) && adv && !abort;
    assign wrap = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        npasses_d = npasses_q;
        wr_mode_d = wr_mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    pass_d    = '0;
                    npasses_d = npasses;
                    wr_mode_d = wr_mode;
                    state_d   = (npasses == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort leaves idx/pass frozen so the caller can recover the rotation
                if (abort) begin
                    state_d = IDLE;
                end else if (step) begin
                    if (wrap) begin
                        idx_d  = '0;
                        pass_d = pass_q + npbits'(1);
                        if (pass_q == (npasses_q - npbits'(1))) begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
                pass_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            npasses_q <= '0;
            wr_mode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            npasses_q <= npasses_d;
            wr_mode_q <= wr_mode_d;
        end
    end

    assign en    = step;
    assign wren  = step && wr_mode_q;
    assign idx   = idx_q;
    assign pass  = pass_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign first = busy && (idx_q == '0);
    assign last  = busy && wrap;

endmodule

// File: tb/tb_ringbuf_seq.sv
// tb/tb_ringbuf_seq.sv - randomized and directed bench for ringbuf_seq
module tb_ringbuf_seq;

    localparam int NW  = 8;
    localparam int NPB = 8;

    logic           clk = 1'b0;
    logic           rstb = 1'b0;
    logic           start = 1'b0;
    logic [NPB-1:0] npasses = '0;
    logic           wr_mode = 1'b0;
    logic           adv = 1'b0;
    logic           abort = 1'b0;
    logic           en, wren, first, last, busy, done;
    logic [2:0]     idx;
    logic [NPB-1:0] pass;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a job is a count of completed steps; idx/pass derive from it.
    int         m_mode;  // 0 idle, 1 running, 2 done pulse
    int         m_steps;
    int         m_total;
    bit         m_wr;
    logic [7:0] rb [NW];
    logic [7:0] d_word;

    always #5 clk = ~clk;

    ringbuf_seq #(.nwords(NW), .npbits(NPB)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .start   (start),
        .npasses (npasses),
        .wr_mode (wr_mode),
        .adv     (adv),
        .abort   (abort),
        .en      (en),
        .wren    (wren),
        .idx     (idx),
        .pass    (pass),
        .first   (first),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [16:0] dut_vec();
        return {en, wren, busy, done, first, last, idx, pass};
    endfunction

    function automatic logic [16:0] exp_vec();
        bit b;
        bit e;
        int ix;
        int ps;
        b  = (m_mode == 1);
        e  = b && (adv === 1'b1) && (abort !== 1'b1);
        ix = m_steps % NW;
        ps = (m_steps / NW) % 256;
        return {e, e && m_wr, b, (m_mode == 2), b && (ix == 0), b && (ix == NW - 1), 3'(ix), 8'(ps)};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_steps = 0;
        m_total = 0;
        m_wr    = 1'b0;
        for (int i = 0; i < NW; i++) rb[i] = '0;
    endtask

    task automatic model_update();
        case (m_mode)
            0: if (start) begin
                m_steps = 0;
                m_total = int'(npasses) * NW;
                m_wr    = wr_mode;
                m_mode  = (npasses == 0) ? 2 : 1;
            end
            1: if (abort) begin
                m_mode = 0;
            end else if (adv) begin
                m_steps++;
                if (m_steps == m_total) m_mode = 2;
            end
            default: begin
                m_mode  = 0;
                m_steps = 0;
            end
        endcase
    endtask

    task automatic set_in(input logic s, input logic [NPB-1:0] np, input logic wm,
                          input logic a, input logic ab);
        start   = s;
        npasses = np;
        wr_mode = wm;
        adv     = a;
        abort   = ab;
    endtask

    // Called mid-cycle; ring rotates on the DUT's own en/wren, then the clock edge.
    task automatic clk_step();
        logic [7:0] t;
        if (en === 1'b1) begin
            t = rb[0];
            for (int i = 0; i < NW - 1; i++) rb[i] = rb[i + 1];
            rb[NW - 1] = (wren === 1'b1) ? d_word : t;
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        #2;
        n_tests++;
        if (dut_vec() !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", dut_vec(), 17'h0);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec() !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", dut_vec(), 17'h0);
        end
        @(negedge clk);
        model_reset();
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        rstb = 1'b1;
    endtask

    task automatic test_full_write();
        int n_en = 0;
        int done_cyc = -1;
        set_in(1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        #2;
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_start got=%h exp=%h", dut_vec(), exp_vec());
        end
        clk_step();
        start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            d_word = 8'(m_steps);
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (en === 1'b1) n_en++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            clk_step();
        end
        n_tests++;
        if (n_en != 16 || done_cyc != 16) begin
            n_fail++;
            $display("FAIL full_counts en=%0d done_cyc=%0d exp en=16 done_cyc=16", n_en, done_cyc);
        end
        for (int i = 0; i < NW; i++) begin
            n_tests++;
            if (rb[i] !== 8'(8 + i)) begin
                n_fail++;
                $display("FAIL full_ring i=%0d got=%0d exp=%0d", i, rb[i], 8 + i);
            end
        end
    endtask

    task automatic test_zero_passes();
        set_in(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL zero_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                n_tests++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_done done=%b busy=%b exp done=1 busy=0", done, busy);
                end
            end
            clk_step();
            start = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat = 4'b1001;
        int done_cyc = -1;
        set_in(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        #2;
        clk_step();
        start = 1'b0;
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            adv = pat[c % 4];
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (done === 1'b1) done_cyc = c;
            clk_step();
        end
        n_tests++;
        if (done_cyc != 16) begin
            n_fail++;
            $display("FAIL stall_latency got=%0d exp=16", done_cyc);
        end
    endtask

    task automatic test_abort_mid();
        set_in(1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        #2;
        clk_step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            clk_step();
        end
        abort = 1'b1;
        #2;
        n_tests++;
        if (dut_vec() !== exp_vec() || en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mid_en got=%h exp=%h", dut_vec(), exp_vec());
        end
        clk_step();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec() || idx !== 3'd5 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_mid_hold c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            clk_step();
        end
    endtask

    task automatic test_abort_final();
        set_in(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        #2;
        clk_step();
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #2;
            clk_step();
        end
        abort = 1'b1;
        #2;
        n_tests++;
        if (dut_vec() !== exp_vec() || en !== 1'b0 || last !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_final_en got=%h exp=%h", dut_vec(), exp_vec());
        end
        clk_step();
        abort = 1'b0;
        #2;
        n_tests++;
        if (dut_vec() !== exp_vec() || done !== 1'b0 || idx !== 3'd7) begin
            n_fail++;
            $display("FAIL abort_final_nodone got=%h exp=%h", dut_vec(), exp_vec());
        end
        clk_step();
    endtask

    task automatic test_reset_mid();
        int n_en = 0;
        set_in(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        #2;
        clk_step();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            clk_step();
        end
        #3;
        rstb = 1'b0;
        #1;
        n_tests++;
        if (dut_vec() !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec(), 17'h0);
        end
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        set_in(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_restart c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (en === 1'b1) n_en++;
            clk_step();
            start = 1'b0;
        end
        n_tests++;
        if (n_en != 8) begin
            n_fail++;
            $display("FAIL reset_restart_count got=%0d exp=8", n_en);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            d_word = 8'($urandom);
            #2;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            clk_step();
        end
    endtask

    initial begin
        model_reset();
        d_word = '0;
        test_reset();
        test_full_write();
        test_zero_passes();
        test_stall();
        test_abort_mid();
        test_abort_final();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
